// File: rtl/vga_text_console_writer.sv
// Text-buffer producer for the 80x30 VGA text renderer: consumes an ASCII stream,
// tracks the cursor and maintains the 600-word glyph buffer (clear, write, scroll).
module vga_text_console_writer #(
  parameter int          H_CHAR_CNT = 80,
  parameter int          V_CHAR_CNT = 30,
  parameter int          BUF_WORDS  = 600,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic        dri_clk,
  input  logic        rst,
  // Handshake: a character transfers on a rising edge where ch_valid && ch_ready;
  // ch_data must be held stable while ch_valid is high and ch_ready is low.
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clr_req,
  output logic        buf_we,
  output logic [9:0]  buf_waddr,
  output logic [31:0] buf_wdata,
  output logic [3:0]  buf_wbe,
  output logic [9:0]  buf_raddr,
  input  logic [31:0] buf_rdata,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_WCHR  = 3'd2,
    S_SC_RD = 3'd3,
    S_SC_WR = 3'd4,
    S_FILL  = 3'd5
  } state_t;

  localparam logic [6:0] LAST_COL  = 7'(H_CHAR_CNT - 1);
  localparam logic [4:0] LAST_ROW  = 5'(V_CHAR_CNT - 1);
  localparam logic [9:0] ROW_WORDS = 10'(H_CHAR_CNT / 4);
  localparam logic [9:0] CLR_END   = 10'(BUF_WORDS);
  localparam logic [9:0] WORD_LAST = 10'(BUF_WORDS - 1);
  localparam logic [9:0] COPY_LAST = 10'(BUF_WORDS - H_CHAR_CNT / 4 - 1);
  localparam logic [31:0] FILL_WORD = {4{FILL_CHAR}};

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [6:0]  cur_x_q;
  logic [4:0]  cur_y_q;
  logic        scroll_q;
  logic        we_q;
  logic [9:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wbe_q;
  logic [9:0]  raddr_q;

  // Decode of the character offered this cycle (used only on accept).
  logic [6:0]  cur_x_d;
  logic [4:0]  cur_y_d;
  logic        acc_wr;
  logic        acc_scroll;
  logic [7:0]  acc_code;
  logic [6:0]  wr_x;
  logic [4:0]  wr_y;
  logic [11:0] wr_idx;

  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    acc_wr     = 1'b0;
    acc_scroll = 1'b0;
    acc_code   = ch_data;
    wr_x       = cur_x_q;
    wr_y       = cur_y_q;
    case (ch_data)
      8'h0D: cur_x_d = 7'd0;
      8'h0A: begin
        cur_x_d = 7'd0;
        if (cur_y_q < LAST_ROW) cur_y_d = cur_y_q + 5'd1;
        else                    acc_scroll = 1'b1;
      end
      8'h08: begin
        acc_code = FILL_CHAR;
        if (cur_x_q != 7'd0) begin
          cur_x_d = cur_x_q - 7'd1;
          acc_wr  = 1'b1;
        end else if (cur_y_q != 5'd0) begin
          cur_x_d = LAST_COL;
          cur_y_d = cur_y_q - 5'd1;
          acc_wr  = 1'b1;
        end
        // Backspace erases at the cell the cursor moves back onto.
        wr_x = cur_x_d;
        wr_y = cur_y_d;
      end
      default: begin
        acc_wr = 1'b1;
        if (cur_x_q < LAST_COL) begin
          cur_x_d = cur_x_q + 7'd1;
        end else begin
          cur_x_d = 7'd0;
          if (cur_y_q < LAST_ROW) cur_y_d = cur_y_q + 5'd1;
          else                    acc_scroll = 1'b1;
        end
      end
    endcase
    wr_idx = 12'(wr_y) * 12'(H_CHAR_CNT) + 12'(wr_x);
  end

  always_ff @(posedge dri_clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      scroll_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wbe_q    <= '0;
      raddr_q  <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q != CLR_END) begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= FILL_WORD;
            wbe_q   <= 4'hF;
            cnt_q   <= cnt_q + 10'd1;
          end else begin
            we_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          we_q <= 1'b0;
          if (clr_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
          end else if (ch_valid) begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            if (acc_wr) begin
              state_q  <= S_WCHR;
              we_q     <= 1'b1;
              waddr_q  <= wr_idx[11:2];
              wdata_q  <= {4{acc_code}};
              wbe_q    <= 4'b0001 << wr_idx[1:0];
              scroll_q <= acc_scroll;
            end else if (acc_scroll) begin
              state_q <= S_SC_RD;
              cnt_q   <= '0;
              raddr_q <= ROW_WORDS;
            end
          end
        end
        S_WCHR: begin
          we_q <= 1'b0;
          if (scroll_q) begin
            state_q  <= S_SC_RD;
            scroll_q <= 1'b0;
            cnt_q    <= '0;
            raddr_q  <= ROW_WORDS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SC_RD: begin
          // Read data for word cnt_q+ROW_WORDS arrives while in SC_WR.
          state_q <= S_SC_WR;
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wbe_q   <= 4'hF;
        end
        S_SC_WR: begin
          if (cnt_q == COPY_LAST) begin
            state_q <= S_FILL;
            cnt_q   <= cnt_q + 10'd1;
            waddr_q <= cnt_q + 10'd1;
            wdata_q <= FILL_WORD;
          end else begin
            state_q <= S_SC_RD;
            we_q    <= 1'b0;
            cnt_q   <= cnt_q + 10'd1;
            raddr_q <= cnt_q + 10'd1 + ROW_WORDS;
          end
        end
        S_FILL: begin
          if (cnt_q == WORD_LAST) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 10'd1;
            waddr_q <= cnt_q + 10'd1;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          cnt_q   <= '0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ch_ready    = (state_q == S_IDLE) && !clr_req;
  assign busy        = (state_q != S_IDLE) && (state_q != S_WCHR);
  assign buf_we      = we_q;
  assign buf_waddr   = waddr_q;
  assign buf_wdata   = (state_q == S_SC_WR) ? buf_rdata : wdata_q;
  assign buf_wbe     = wbe_q;
  assign buf_raddr   = raddr_q;
  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign dbg_state_o = state_q;

endmodule
